// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths and the packed float layout.
// Used by both fixed<->float converters on the matrix multiplier datapath.
package fp_pkg;

  localparam int FP_EXP_W         = 8;
  localparam int FP_MANT_W        = 23;
  localparam int FP_BIAS          = 127;
  localparam int FP_FRAC_BITS_DEF = 16;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

  localparam fp32_t FP32_ZERO = '0;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
// Zero latency, no handshake.
module lzc32 (
  input  logic [31:0] i_dat,
  output logic [5:0]  o_cnt
);

  logic [5:0] w_cnt;

  // Scan upward so the highest set bit wins the last assignment.
  always_comb begin
    w_cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (i_dat[i]) w_cnt = 6'(31 - i);
    end
  end

  assign o_cnt = w_cnt;

endmodule

// File: rtl/fixed_to_float_pipe.sv
// Signed Q(32-FRAC_BITS).FRAC_BITS -> IEEE-754 single, round-to-nearest-even.
// 3-cycle latency, 1 word/clk; whole pipe holds while the output is valid and not accepted.
module fixed_to_float_pipe
  import fp_pkg::*;
#(
  parameter int FRAC_BITS = FP_FRAC_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fixed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_float
);

  // Biased exponent of a value whose leading one sits at bit 31 of the magnitude.
  localparam int EXP_BASE = 31 + FP_BIAS - FRAC_BITS;

  logic        r_s1_vld;
  logic        r_s1_sign;
  logic        r_s1_zero;
  logic [31:0] r_s1_mag;

  logic        r_s2_vld;
  logic        r_s2_sign;
  logic        r_s2_zero;
  logic [31:0] r_s2_norm;
  logic [7:0]  r_s2_exp;

  logic        r_out_vld;
  fp32_t       r_out_float;

  logic        w_advance;
  logic [31:0] w_mag;
  logic [5:0]  w_lzc;
  logic [31:0] w_norm;
  logic [7:0]  w_exp_pre;
  logic [22:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_rnd_up;
  logic [23:0] w_mant_rnd;
  fp32_t       w_result;

  assign w_advance = !r_out_vld || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_out_vld;
  assign out_float = r_out_float;

  // 32-bit negate is enough: 32'h80000000 negates to itself, read unsigned as 2^31.
  assign w_mag = in_fixed[31] ? (~in_fixed + 32'd1) : in_fixed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_mag  <= '0;
    end else if (w_advance) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_fixed[31];
        r_s1_zero <= (in_fixed == 32'd0);
        r_s1_mag  <= w_mag;
      end
    end
  end

  lzc32 u_lzc (
    .i_dat (r_s1_mag),
    .o_cnt (w_lzc)
  );

  assign w_norm    = r_s1_mag << w_lzc;
  assign w_exp_pre = 8'(EXP_BASE - int'(w_lzc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_sign <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_norm <= '0;
      r_s2_exp  <= '0;
    end else if (w_advance) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_sign <= r_s1_sign;
        r_s2_zero <= r_s1_zero;
        r_s2_norm <= w_norm;
        r_s2_exp  <= w_exp_pre;
      end
    end
  end

  assign w_mant     = r_s2_norm[30:8];
  assign w_guard    = r_s2_norm[7];
  assign w_sticky   = |r_s2_norm[6:0];
  assign w_rnd_up   = w_guard && (w_sticky || w_mant[0]);
  assign w_mant_rnd = {1'b0, w_mant} + {23'd0, w_rnd_up};

  // A carry out of the mantissa leaves it all zeros, so only the exponent bumps.
  always_comb begin
    w_result      = FP32_ZERO;
    w_result.sign = r_s2_sign;
    w_result.exp  = r_s2_exp + {7'd0, w_mant_rnd[23]};
    w_result.mant = w_mant_rnd[22:0];
    if (r_s2_zero) w_result = FP32_ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld   <= 1'b0;
      r_out_float <= FP32_ZERO;
    end else if (w_advance) begin
      r_out_vld <= r_s2_vld;
      if (r_s2_vld) r_out_float <= w_result;
    end
  end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Self-checking bench for fixed_to_float_pipe: directed vectors plus a
// randomized scoreboard against a double-precision reference conversion.
module tb_fixed_to_float_pipe;

  localparam int FRAC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fixed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;

  int errs   = 0;
  int checks = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  fixed_to_float_pipe #(.FRAC_BITS(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fixed  (in_fixed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float)
  );

  // Real value of the fixed word, expressed exactly as a double, then rounded
  // to single precision with round-to-nearest-even on the double's fraction.
  function automatic logic [31:0] ref_conv(input logic [31:0] x);
    real         r;
    logic [63:0] d;
    logic [23:0] m;
    logic        g;
    logic        st;
    int          e;
    if (x == 32'd0) return 32'd0;
    r  = $itor($signed(x)) / (2.0 ** FRAC);
    d  = $realtobits(r);
    m  = {1'b0, d[51:29]};
    g  = d[28];
    st = |d[27:0];
    if (g && (st || m[0])) m = m + 24'd1;
    e = int'(d[62:52]) - 1023 + 127 + int'(m[23]);
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    case ($urandom_range(0, 5))
      0:       w = $urandom;
      1:       w = 32'($urandom_range(0, 255));
      2:       w = -32'($urandom_range(1, 70000));
      3:       w = 32'h00FFFF80 + 32'($urandom_range(0, 255));
      4: begin
        case ($urandom_range(0, 3))
          0:       w = 32'h80000000;
          1:       w = 32'h7FFFFFFF;
          2:       w = 32'h00000000;
          default: w = 32'hFFFFFFFF;
        endcase
      end
      default: w = 32'h01000000 | 32'($urandom_range(0, 7));
    endcase
    return w;
  endfunction

  // Drive one cycle's inputs, sample outputs on the falling edge, then step past the rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      output logic ov, output logic [31:0] of, output logic ir);
    in_valid  = v;
    in_fixed  = v ? d : 32'bx;
    out_ready = r;
    @(negedge clk);
    ov = out_valid;
    of = out_float;
    ir = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_fixed  = 32'd0;
    out_ready = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_float !== 32'd0) begin errs++; $display("FAIL reset_out_float: got %h expected 00000000", out_float); end
    checks++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] vin [7];
    logic [31:0] vexp[7];
    logic        ov, ir;
    logic [31:0] of;
    vin[0] = 32'h0003E000; vexp[0] = 32'h40780000;
    vin[1] = 32'h00000000; vexp[1] = 32'h00000000;
    vin[2] = 32'hFFFF0000; vexp[2] = 32'hBF800000;
    vin[3] = 32'h80000000; vexp[3] = 32'hC7000000;
    vin[4] = 32'h7FFFFFFF; vexp[4] = 32'h47000000;
    vin[5] = 32'h01000001; vexp[5] = 32'h43800000;
    vin[6] = 32'h01000003; vexp[6] = 32'h43800002;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vin[i], 1'b1, ov, of, ir);
      checks++;
      if (ir !== 1'b1) begin errs++; $display("FAIL dir_in_ready[%0d]: got %b expected 1", i, ir); end
      for (int k = 1; k <= 3; k++) begin
        step(1'b0, 32'd0, 1'b1, ov, of, ir);
        if (k < 3) begin
          checks++;
          if (ov !== 1'b0) begin errs++; $display("FAIL dir_early_valid[%0d] cyc %0d: got %b expected 0", i, k, ov); end
        end else begin
          checks++;
          if (ov !== 1'b1) begin errs++; $display("FAIL dir_latency[%0d]: got out_valid %b expected 1", i, ov); end
          checks++;
          if (of !== vexp[i]) begin errs++; $display("FAIL dir_value[%0d] in %h: got %h expected %h", i, vin[i], of, vexp[i]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[8];
    logic        ov, ir, v, r;
    logic [31:0] of, prev_of, exp_v;
    logic        prev_stall = 1'b0;
    logic        stall_seen = 1'b0;
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    for (int i = 0; i < 8; i++) words[i] = gen_word();
    sb.delete();
    prev_of = 32'd0;
    while (got < 8 && cyc < 100) begin
      v = (sent < 8);
      r = !(cyc >= 5 && cyc < 8);
      step(v, v ? words[sent] : 32'd0, r, ov, of, ir);
      checks++;
      if (ir !== (!ov || r)) begin errs++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, ir, (!ov || r)); end
      if (ov && !r && !ir) stall_seen = 1'b1;
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || of !== prev_of) begin
          errs++; $display("FAIL b2b_hold cyc %0d: got %b/%h expected 1/%h", cyc, ov, of, prev_of);
        end
      end
      prev_stall = ov && !r;
      prev_of    = of;
      if (ov && r) begin
        checks++;
        if (sb.size() == 0) begin
          errs++; $display("FAIL b2b_extra_output: got %h expected none", of);
        end else begin
          exp_v = sb.pop_front();
          if (of !== exp_v) begin errs++; $display("FAIL b2b_value #%0d: got %h expected %h", got, of, exp_v); end
        end
        got++;
      end
      if (v && ir) begin
        sb.push_back(ref_conv(words[sent]));
        sent++;
      end
      cyc++;
    end
    checks++;
    if (got != 8) begin errs++; $display("FAIL b2b_count: got %0d expected 8", got); end
    checks++;
    if (!stall_seen) begin errs++; $display("FAIL b2b_stall_seen: got 0 expected 1"); end
    step(1'b0, 32'd0, 1'b1, ov, of, ir);
    checks++;
    if (ov !== 1'b0) begin errs++; $display("FAIL b2b_duplicate: got out_valid %b expected 0", ov); end
  endtask

  task automatic test_random();
    logic        ov, ir, v, r;
    logic [31:0] of, d, exp_v;
    int          drain = 0;
    sb.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      d = gen_word();
      step(v, d, r, ov, of, ir);
      if (ov && r) begin
        checks++;
        if (sb.size() == 0) begin
          errs++; $display("FAIL rnd_extra_output: got %h expected none", of);
        end else begin
          exp_v = sb.pop_front();
          if (of !== exp_v) begin errs++; $display("FAIL rnd_value cyc %0d: got %h expected %h", cyc, of, exp_v); end
        end
      end
      if (v && ir) sb.push_back(ref_conv(d));
    end
    while (sb.size() != 0 && drain < 20) begin
      step(1'b0, 32'd0, 1'b1, ov, of, ir);
      if (ov) begin
        exp_v = sb.pop_front();
        checks++;
        if (of !== exp_v) begin errs++; $display("FAIL rnd_drain_value: got %h expected %h", of, exp_v); end
      end
      drain++;
    end
    checks++;
    if (sb.size() != 0) begin errs++; $display("FAIL rnd_drain_timeout: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic        ov, ir;
    logic [31:0] of, w, exp_v;
    logic        stale = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, gen_word(), 1'b1, ov, of, ir);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errs++; $display("FAIL rst_mid_pre_valid: got %b expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_async_drop: got %b expected 0", out_valid); end
    checks++;
    if (out_float !== 32'd0) begin errs++; $display("FAIL rst_mid_float_clear: got %h expected 00000000", out_float); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0, 1'b1, ov, of, ir);
      if (ov) stale = 1'b1;
    end
    checks++;
    if (stale) begin errs++; $display("FAIL rst_mid_stale_output: got 1 expected 0"); end
    w     = gen_word();
    exp_v = ref_conv(w);
    step(1'b1, w, 1'b1, ov, of, ir);
    for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 1'b1, ov, of, ir);
    checks++;
    if (ov !== 1'b1 || of !== exp_v) begin
      errs++; $display("FAIL rst_mid_next_word in %h: got %b/%h expected 1/%h", w, ov, of, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
